// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding, the boot address and the sequential PC step.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0020;
    localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/fetch_seq_pc_reg.sv
// Loadable program-counter register with a synchronous reset value.
module pc_reg #(
    parameter int unsigned     W         = 32,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Hold the PC unless the sequencer asks for a new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks the PC, issues one memory request at a
// time, hands returned words to decode and handles branch/jump redirects.
//
// Memory handshake: imem_req is a request that stays asserted with a stable
// imem_addr until the cycle in which imem_ack is high; that ack cycle
// completes the request and imem_rdata is valid only in it. The memory may
// not retract an ack and the sequencer never withdraws a request, so a
// redirect during an outstanding request drains it (DRAIN) and drops its data.
// Decode side: instr is consumed in any cycle with instr_valid=1 and stall=0.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic              take_branch,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              flush,
    output logic              misalign,
    output fetch_state_e      dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_load;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;

    logic              redirect;
    logic [ADDR_W-1:0] redir_tgt;

    // Jump wins over a same-cycle taken branch.
    assign redirect  = jump | (br_valid & take_branch);
    assign redir_tgt = jump ? jump_target : br_target;

    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // Next-state, PC update and decode-slot logic; redirect overrides all.
    always_comb begin
        state_d       = state_q;
        pc_load       = 1'b0;
        pc_d          = pc_q + ADDR_W'(PC_INCR);
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q & stall;
        flush_d       = 1'b0;
        misalign_d    = misalign_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    // A held, unconsumed word must not be overwritten; the
                    // returned word is dropped and refetched from the same pc.
                    if (!stall || !instr_valid_q) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_load       = 1'b1;
                    end
                    state_d = stall ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (redirect) begin
            pc_load       = 1'b1;
            pc_d          = {redir_tgt[ADDR_W-1:2], 2'b00};
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            flush_d       = 1'b1;
            if (redir_tgt[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            // A request still waiting for its ack must be drained at the
            // address it was issued with.
            if ((state_q == ST_REQ || state_q == ST_DRAIN) && !imem_ack) begin
                state_d = ST_DRAIN;
                if (state_q == ST_REQ) begin
                    addr_d = pc_q;
                end
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            addr_q        <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr   = (state_q == ST_DRAIN) ? addr_q : pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign flush       = flush_q;
    assign misalign    = misalign_q;
    assign dbg_state   = state_q;

endmodule
